// File: rtl/gpu_pkg.sv
// Shared cache definitions: FSM state encoding and address-split width helpers.
package gpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_FILL      = 3'd3,
    ST_RESPOND   = 3'd4
  } cache_state_t;

  // Pointer width that stays legal for a single-entry structure.
  function automatic int ptr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int index_bits(input int num_sets);
    return ptr_bits(num_sets);
  endfunction

  function automatic int tag_bits(input int addr_bits, input int num_sets);
    return addr_bits - index_bits(num_sets);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts after the last granted port.
// Pointer moves only when advance is high and something was granted.
module rr_arbiter
  import gpu_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] request,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = ptr_bits(NUM_REQ);

  logic [PTR_W-1:0] start_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic             found;

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && request[wrap_idx(start_ptr, k)]) begin
        found     = 1'b1;
        grant_idx = wrap_idx(start_ptr, k);
      end
    end
    grant[grant_idx] = found;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_ptr <= '0;
    end else if (advance && found) begin
      start_ptr <= wrap_idx(grant_idx, 1);
    end
  end

endmodule

// File: rtl/dcache_wb.sv
// Multi-port write-back, write-allocate set-associative data cache, one word per line.
// Hit: 3 cycles valid->ready; misses stall on mem ready handshakes; ready held until the port drops valid.
module dcache_wb
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_SETS      = 4,
  parameter int NUM_WAYS      = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic                                    mem_read_valid,
  output logic [ADDR_BITS-1:0]                    mem_read_address,
  input  logic                                    mem_read_ready,
  input  logic [DATA_BITS-1:0]                    mem_read_data,
  output logic                                    mem_write_valid,
  output logic [ADDR_BITS-1:0]                    mem_write_address,
  output logic [DATA_BITS-1:0]                    mem_write_data,
  input  logic                                    mem_write_ready
);

  localparam int IDX_W  = index_bits(NUM_SETS);
  localparam int TAG_W  = tag_bits(ADDR_BITS, NUM_SETS);
  localparam int WAY_W  = ptr_bits(NUM_WAYS);
  localparam int PORT_W = ptr_bits(NUM_CONSUMERS);

  logic [TAG_W-1:0]     tag_mem  [NUM_SETS][NUM_WAYS];
  logic [DATA_BITS-1:0] data_mem [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]  valid_q  [NUM_SETS];
  logic [NUM_WAYS-1:0]  dirty_q  [NUM_SETS];
  logic [WAY_W-1:0]     vptr_q   [NUM_SETS];

  cache_state_t state, state_next;

  logic [PORT_W-1:0]    port_q;
  logic                 is_read_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] wdata_q;
  logic [DATA_BITS-1:0] resp_data_q;
  logic [WAY_W-1:0]     victim_q;
  logic [ADDR_BITS-1:0] wb_addr_q;
  logic [DATA_BITS-1:0] wb_data_q;
  logic                 armed_q;

  logic [NUM_CONSUMERS-1:0] request;
  logic [NUM_CONSUMERS-1:0] grant;
  logic [PORT_W-1:0]        grant_idx;
  logic                     port_valid;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             has_invalid;
  logic [WAY_W-1:0] invalid_way;
  logic [WAY_W-1:0] victim;
  logic             victim_dirty;

  assign request    = consumer_read_valid | consumer_write_valid;
  assign idx        = addr_q[IDX_W-1:0];
  assign tag        = addr_q[ADDR_BITS-1:IDX_W];
  assign port_valid = is_read_q ? consumer_read_valid[port_q] : consumer_write_valid[port_q];

  rr_arbiter #(
    .NUM_REQ (NUM_CONSUMERS)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .request (request),
    .advance (state == ST_IDLE),
    .grant   (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      if (grant[i]) grant_idx = PORT_W'(i);
    end
  end

  // Victim choice: first free way, otherwise the set's rotating pointer.
  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    has_invalid = 1'b0;
    invalid_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[idx][w] && (tag_mem[idx][w] == tag) && !hit) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w] && !has_invalid) begin
        has_invalid = 1'b1;
        invalid_way = WAY_W'(w);
      end
    end
    victim       = has_invalid ? invalid_way : vptr_q[idx];
    victim_dirty = valid_q[idx][victim] && dirty_q[idx][victim];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (|request) state_next = ST_LOOKUP;
      ST_LOOKUP: begin
        if (hit)               state_next = ST_RESPOND;
        else if (victim_dirty) state_next = ST_WRITEBACK;
        else if (is_read_q)    state_next = ST_FILL;
        else                   state_next = ST_RESPOND;
      end
      ST_WRITEBACK: if (mem_write_ready) state_next = is_read_q ? ST_FILL : ST_RESPOND;
      ST_FILL:      if (mem_read_ready) state_next = ST_RESPOND;
      ST_RESPOND:   if (armed_q && !port_valid) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    consumer_read_ready  = '0;
    consumer_read_data   = '0;
    consumer_write_ready = '0;
    mem_read_valid       = (state == ST_FILL);
    mem_read_address     = (state == ST_FILL) ? addr_q : '0;
    mem_write_valid      = (state == ST_WRITEBACK);
    mem_write_address    = (state == ST_WRITEBACK) ? wb_addr_q : '0;
    mem_write_data       = (state == ST_WRITEBACK) ? wb_data_q : '0;
    if ((state == ST_RESPOND) && armed_q) begin
      if (is_read_q) begin
        consumer_read_ready[port_q] = 1'b1;
        consumer_read_data[port_q]  = resp_data_q;
      end else begin
        consumer_write_ready[port_q] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        vptr_q[s]  <= '0;
      end
      port_q      <= '0;
      is_read_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
      victim_q    <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      armed_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (|request) begin
          port_q    <= grant_idx;
          is_read_q <= consumer_read_valid[grant_idx];
          addr_q    <= consumer_read_valid[grant_idx] ? consumer_read_address[grant_idx]
                                                      : consumer_write_address[grant_idx];
          wdata_q   <= consumer_write_data[grant_idx];
        end
        ST_LOOKUP: begin
          if (hit) begin
            if (is_read_q) begin
              resp_data_q <= data_mem[idx][hit_way];
            end else begin
              data_mem[idx][hit_way]   <= wdata_q;
              dirty_q[idx][hit_way]    <= 1'b1;
            end
          end else begin
            // Victim snapshot is taken before a write miss overwrites the line.
            victim_q  <= victim;
            wb_addr_q <= {tag_mem[idx][victim], idx};
            wb_data_q <= data_mem[idx][victim];
            if (!has_invalid) begin
              vptr_q[idx] <= (vptr_q[idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : vptr_q[idx] + 1'b1;
            end
            if (!is_read_q) begin
              tag_mem[idx][victim]  <= tag;
              data_mem[idx][victim] <= wdata_q;
              valid_q[idx][victim]  <= 1'b1;
              dirty_q[idx][victim]  <= 1'b1;
            end
          end
        end
        ST_FILL: if (mem_read_ready) begin
          tag_mem[idx][victim_q]  <= tag;
          data_mem[idx][victim_q] <= mem_read_data;
          valid_q[idx][victim_q]  <= 1'b1;
          dirty_q[idx][victim_q]  <= 1'b0;
          resp_data_q             <= mem_read_data;
        end
        ST_RESPOND: begin
          if (!armed_q)         armed_q <= 1'b1;
          else if (!port_valid) armed_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Self-checking bench for dcache_wb: golden memory plus a cache-residency model predict data and traffic.
module tb_dcache_wb;

  localparam int NSETS = 4;
  localparam int NWAYS = 2;
  localparam int TMO   = 300;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      crv, cwv, crr, cwr;
  logic [3:0][7:0] cra, cwa, cwd, crd;
  logic            mrv, mrr, mwv, mwr;
  logic [7:0]      mra, mrd, mwa, mwd;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem_model [256];
  logic [7:0] golden    [256];
  logic [7:0] rd_log [$];
  logic [7:0] wr_log_a [$];
  logic [7:0] wr_log_d [$];
  logic [7:0] last_rdata;
  bit         fill_stall = 1'b0;

  bit m_valid [NSETS][NWAYS];
  bit m_dirty [NSETS][NWAYS];
  int m_tag   [NSETS][NWAYS];
  int m_ptr   [NSETS];

  always #5 clk = ~clk;

  dcache_wb #(
    .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_SETS(NSETS), .NUM_WAYS(NWAYS)
  ) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(cwv), .consumer_write_address(cwa),
    .consumer_write_data(cwd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra), .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd), .mem_write_ready(mwr)
  );

  // Memory responder with random latency; logs every accepted transfer.
  initial begin
    int rd_wait, wr_wait;
    rd_wait = 0; wr_wait = 0;
    mrr = 1'b0; mwr = 1'b0; mrd = '0;
    forever begin
      @(negedge clk);
      mrr = 1'b0; mwr = 1'b0; mrd = 8'($urandom);
      if (mrv && mwv) begin
        n_checks++; n_fail++;
        $display("FAIL mem_exclusive: read_valid=%b write_valid=%b, required not both", mrv, mwv);
      end
      if (mwv) begin
        if (wr_wait == 0) begin
          mwr = 1'b1;
          wr_log_a.push_back(mwa); wr_log_d.push_back(mwd);
          mem_model[mwa] = mwd;
          wr_wait = $urandom_range(0, 3);
        end else wr_wait--;
      end
      if (mrv && !fill_stall) begin
        if (rd_wait == 0) begin
          mrr = 1'b1; mrd = mem_model[mra];
          rd_log.push_back(mra);
          rd_wait = $urandom_range(0, 3);
        end else rd_wait--;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < NWAYS; w++) begin
        m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = 0;
      end
    end
    for (int a = 0; a < 256; a++) golden[a] = mem_model[a];
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    crv = '0; cwv = '0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Residency model: hit/miss, eviction choice, and whether memory is touched.
  task automatic predict(input bit rd, input logic [7:0] addr, output bit hit, output bit wb,
                         output logic [7:0] wba, output bit fill);
    int s, t, v;
    s = int'(addr) % NSETS; t = int'(addr) / NSETS;
    hit = 0; wb = 0; wba = '0; fill = 0; v = -1;
    for (int w = 0; w < NWAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) begin hit = 1; v = w; end
    if (hit) begin
      if (!rd) m_dirty[s][v] = 1;
      return;
    end
    for (int w = NWAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
    if (v < 0) begin v = m_ptr[s]; m_ptr[s] = (m_ptr[s] + 1) % NWAYS; end
    wb  = m_valid[s][v] && m_dirty[s][v];
    wba = 8'(m_tag[s][v] * NSETS + s);
    m_valid[s][v] = 1; m_tag[s][v] = t; m_dirty[s][v] = !rd; fill = rd;
  endtask

  task automatic do_access(input int p, input bit rd, input logic [7:0] addr,
                           input logic [7:0] wd, input int hold);
    bit hit, wb, fill, got, stray, dropped;
    logic [7:0] wba;
    int nr, nw, cyc, held;
    predict(rd, addr, hit, wb, wba, fill);
    nr = rd_log.size(); nw = wr_log_a.size();
    @(negedge clk);
    if (rd) begin crv[p] = 1'b1; cra[p] = addr; end
    else begin cwv[p] = 1'b1; cwa[p] = addr; cwd[p] = wd; end
    cyc = 0; got = 0; stray = 0;
    while (!got && cyc < TMO) begin
      @(negedge clk); cyc++;
      for (int q = 0; q < 4; q++)
        if (q != p && (crr[q] || cwr[q])) stray = 1;
      if (rd ? cwr[p] : crr[p]) stray = 1;
      got = rd ? crr[p] : cwr[p];
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL ready_timeout: port %0d addr %02h no ready after %0d cycles, required ready", p, addr, cyc);
      crv[p] = 1'b0; cwv[p] = 1'b0;
      return;
    end
    last_rdata = crd[p];
    if (hit) begin
      n_checks++;
      if (cyc !== 3) begin
        n_fail++; $display("FAIL hit_latency: port %0d addr %02h got %0d cycles, required 3", p, addr, cyc);
      end
    end
    if (rd) begin
      n_checks++;
      if (crd[p] !== golden[addr]) begin
        n_fail++; $display("FAIL read_data: port %0d addr %02h got %02h, required %02h", p, addr, crd[p], golden[addr]);
      end
    end
    n_checks++;
    if ((rd_log.size() - nr) != int'(fill) || (fill && rd_log[nr] !== addr)) begin
      n_fail++; $display("FAIL fill_traffic: addr %02h got %0d reads, required %0d @%02h", addr, rd_log.size() - nr, fill, addr);
    end
    n_checks++;
    if ((wr_log_a.size() - nw) != int'(wb) ||
        (wb && (wr_log_a[nw] !== wba || wr_log_d[nw] !== golden[wba]))) begin
      n_fail++; $display("FAIL writeback_traffic: addr %02h got %0d writes, required %0d @%02h=%02h", addr, wr_log_a.size() - nw, wb, wba, golden[wba]);
    end
    held = 1; dropped = 0;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      if (rd ? crr[p] : cwr[p]) held++;
    end
    crv[p] = 1'b0; cwv[p] = 1'b0;
    @(negedge clk);
    if (rd ? crr[p] : cwr[p]) dropped = 1;
    n_checks++;
    if (held != hold || dropped || stray) begin
      n_fail++; $display("FAIL ready_hold: port %0d held %0d dropped_late=%0d stray=%0d, required held %0d 0 0", p, held, dropped, stray, hold);
    end
    if (!rd) golden[addr] = wd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({crr, cwr, crd} !== '0) begin
      n_fail++; $display("FAIL reset_consumer_out: got %h, required 0", {crr, cwr, crd});
    end
    n_checks++;
    if ({mrv, mra, mwv, mwa, mwd} !== '0) begin
      n_fail++; $display("FAIL reset_mem_out: got %h, required 0", {mrv, mra, mwv, mwa, mwd});
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({crr, cwr, mrv, mwv} !== '0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b, required 0", {crr, cwr, mrv, mwv});
    end
    model_reset();
  endtask

  task automatic test_cold_read();
    mem_model[8'h05] = 8'hAB; golden[8'h05] = 8'hAB;
    do_access(0, 1, 8'h05, 8'h00, 1);
    n_checks++;
    if (last_rdata !== 8'hAB) begin
      n_fail++; $display("FAIL cold_read: got %02h, required AB", last_rdata);
    end
    do_access(0, 1, 8'h05, 8'h00, 1);
  endtask

  task automatic test_write_then_read();
    do_access(1, 0, 8'h05, 8'h11, 1);
    do_access(1, 1, 8'h05, 8'h00, 1);
    n_checks++;
    if (last_rdata !== 8'h11) begin
      n_fail++; $display("FAIL write_then_read: got %02h, required 11", last_rdata);
    end
  endtask

  task automatic test_reset_during_fill();
    int cyc;
    fill_stall = 1'b1;
    @(negedge clk);
    crv[0] = 1'b1; cra[0] = 8'h22;
    cyc = 0;
    while (!mrv && cyc < TMO) begin @(negedge clk); cyc++; end
    n_checks++;
    if (!mrv || mra !== 8'h22) begin
      n_fail++; $display("FAIL fill_request: valid=%b addr=%02h, required 1 @22", mrv, mra);
    end
    reset = 1'b1; crv[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({crr, cwr, crd, mrv, mra, mwv, mwa, mwd} !== '0) begin
      n_fail++; $display("FAIL reset_mid_fill: got %h, required 0", {crr, cwr, crd, mrv, mra, mwv, mwa, mwd});
    end
    reset = 1'b0; fill_stall = 1'b0;
    model_reset();
    do_access(0, 1, 8'h22, 8'h00, 1);
    // Dirty 0x05 was discarded, so memory's original value must come back.
    do_access(2, 1, 8'h05, 8'h00, 1);
  endtask

  task automatic test_writeback();
    pulse_reset();
    do_access(0, 0, 8'h01, 8'h5A, 1);
    do_access(1, 0, 8'h05, 8'hC3, 1);
    do_access(3, 1, 8'h09, 8'h00, 1);
    n_checks++;
    if (wr_log_a.size() == 0 || wr_log_a[$] !== 8'h01 || wr_log_d[$] !== 8'h5A) begin
      n_fail++; $display("FAIL evict_0x01: last write %02h=%02h, required 01=5A",
                         wr_log_a.size() ? wr_log_a[$] : 8'h00, wr_log_d.size() ? wr_log_d[$] : 8'h00);
    end
    n_checks++;
    if (rd_log.size() == 0 || rd_log[$] !== 8'h09) begin
      n_fail++; $display("FAIL fill_0x09: last read %02h, required 09", rd_log.size() ? rd_log[$] : 8'h00);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] a [4];
    bit done [4];
    int order [$];
    int cyc, cnt, multi;
    bit h, wb, f;
    logic [7:0] wba;
    pulse_reset();
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 4; p++) begin
        a[p] = 8'($urandom_range(0, 63)); done[p] = 0;
        predict(1, a[p], h, wb, wba, f);
      end
      order.delete(); multi = 0; cyc = 0;
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin crv[p] = 1'b1; cra[p] = a[p]; end
      while (order.size() < 4 && cyc < TMO * 4) begin
        @(negedge clk); cyc++; cnt = 0;
        for (int p = 0; p < 4; p++) if (crr[p]) begin
          cnt++;
          if (!done[p]) begin
            done[p] = 1; order.push_back(p);
            n_checks++;
            if (crd[p] !== golden[a[p]]) begin
              n_fail++; $display("FAIL rr_data: port %0d got %02h, required %02h", p, crd[p], golden[a[p]]);
            end
            crv[p] = 1'b0;
          end
        end
        if (cnt > 1) multi++;
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (i >= order.size() || order[i] != i) begin
          n_fail++; $display("FAIL rr_order: round %0d slot %0d got %0d, required %0d", r, i, (i < order.size()) ? order[i] : -1, i);
        end
      end
      n_checks++;
      if (multi != 0) begin
        n_fail++; $display("FAIL rr_single_ready: %0d cycles with multiple readies, required 0", multi);
      end
      crv = '0;
      @(negedge clk);
    end
  endtask

  task automatic test_hold();
    bit h, wb, f, got, bad;
    logic [7:0] wba;
    int cyc, held;
    predict(1, 8'h30, h, wb, wba, f);
    predict(1, 8'h31, h, wb, wba, f);
    @(negedge clk);
    crv[2] = 1'b1; cra[2] = 8'h30;
    cyc = 0;
    while (!crr[2] && cyc < TMO) begin @(negedge clk); cyc++; end
    crv[0] = 1'b1; cra[0] = 8'h31;
    held = crr[2] ? 1 : 0; bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (crr[2]) held++;
      if (crr[0]) bad = 1;
    end
    n_checks++;
    if (held != 5 || bad || crd[2] !== golden[8'h30]) begin
      n_fail++; $display("FAIL hold_ready: held %0d other_ready=%0d data %02h, required 5 0 %02h", held, bad, crd[2], golden[8'h30]);
    end
    crv[2] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (crr[2] !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: ready=%b, required 0", crr[2]);
    end
    cyc = 0; got = 0;
    while (!got && cyc < TMO) begin @(negedge clk); cyc++; got = crr[0]; end
    n_checks++;
    if (!got || crd[0] !== golden[8'h31]) begin
      n_fail++; $display("FAIL hold_next_grant: ready=%b data %02h, required 1 %02h", got, crd[0], golden[8'h31]);
    end
    crv[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      do_access($urandom_range(0, 3), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)),
                8'($urandom), $urandom_range(1, 3));
  endtask

  initial begin
    crv = '0; cwv = '0; cra = '0; cwa = '0; cwd = '0; reset = 1'b1;
    for (int a = 0; a < 256; a++) mem_model[a] = 8'($urandom);
    test_reset();
    test_cold_read();
    test_write_then_read();
    test_reset_during_fill();
    test_writeback();
    test_round_robin();
    test_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
